// File: rtl/uart_tx_fifo.sv
// Byte FIFO from UART THR writes to the transmit serializer, first-word-fall-through.
// Write to rd_valid takes 1 clock; a write is dropped when full unless a pop frees a slot.
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int LOW_THRESH = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          wr_req,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          thr_low,
    output logic          ovr_err,
    input  logic          ovr_clr,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    input  logic          rd_ready
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LOW_LVL  = (AW+1)'(LOW_THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovr_err_q, ovr_err_d;

    // Entry 0 is the head after reset, so it alone carries a reset value.
    logic [7:0]    mem0_q, mem0_d;
    logic [7:0]    memr_q [1:DEPTH-1];
    logic [7:0]    memr_d [1:DEPTH-1];

    logic          pop;
    logic          push;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign thr_low  = (level_q <= LOW_LVL);
    assign level    = level_q;
    assign ovr_err  = ovr_err_q;
    assign rd_valid = ~empty;
    assign rd_data  = (rd_ptr_q == '0) ? mem0_q : memr_q[rd_ptr_q];

    always_comb begin
        pop       = rd_valid & rd_ready;
        push      = wr_req & (~full | pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovr_err_d = ovr_err_q;
        mem0_d    = mem0_q;
        memr_d    = memr_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                if (wr_ptr_q == '0) begin
                    mem0_d = wr_data;
                end else begin
                    memr_d[wr_ptr_q] = wr_data;
                end
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end

        // A dropped write outranks a same-cycle clear request.
        if (wr_req && full && !pop && !clr) begin
            ovr_err_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovr_err_q <= 1'b0;
            mem0_q    <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovr_err_q <= ovr_err_d;
            mem0_q    <= mem0_d;
        end
    end

    always_ff @(posedge clk) begin
        memr_q <= memr_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, pops are compared in order.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          clr = 1'b0;
    logic          wr_req = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, thr_low, ovr_err, rd_valid;
    logic [AW:0]   level;
    logic          ovr_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_ready = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    mq[$];
    logic          exp_ovr = 1'b0;
    int            pops = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .LOW_THRESH(2)) dut (
        .clk(clk), .resetn(resetn), .clr(clr),
        .wr_req(wr_req), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .thr_low(thr_low),
        .ovr_err(ovr_err), .ovr_clr(ovr_clr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn) assert (level <= 5'(DEPTH)) else $error("level out of range: %0d", level);
    end

    // Drive one cycle from a negedge; pops are checked against the scoreboard head.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic oc);
        int  orig;
        logic p;
        orig = mq.size();
        wr_req = w; wr_data = d; rd_ready = r; clr = c; ovr_clr = oc;
        p = r && (orig != 0) && !c;
        if (p) begin
            checks++;
            if (rd_data !== mq[0]) begin
                errors++;
                $display("FAIL pop_data: got %h expected %h", rd_data, mq[0]);
            end
            void'(mq.pop_front());
            pops++;
        end
        if (c) begin
            mq.delete();
        end else if (w && (orig < DEPTH || p)) begin
            mq.push_back(d);
        end
        if (w && !c && orig == DEPTH && !p) exp_ovr = 1'b1;
        else if (oc) exp_ovr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wr_req = 1'b0; rd_ready = 1'b0; clr = 1'b0; ovr_clr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks += 7;
        if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        if (full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        if (level !== 5'd0)    begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (thr_low !== 1'b1)  begin errors++; $display("FAIL rst_thr_low: got %b expected 1", thr_low); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        if (ovr_err !== 1'b0)  begin errors++; $display("FAIL rst_ovr_err: got %b expected 0", ovr_err); end
        if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h expected 00", rd_data); end
        @(negedge clk);
        resetn = 1'b1;
        mq.delete(); exp_ovr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rd_valid); end
        if (rd_data !== 8'h41) begin errors++; $display("FAIL basic_head: got %h expected 41", rd_data); end
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (level !== 5'd3)   begin errors++; $display("FAIL basic_level: got %0d expected 3", level); end
        if (thr_low !== 1'b0) begin errors++; $display("FAIL basic_thr_low: got %b expected 0", thr_low); end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (empty !== 1'b1)  begin errors++; $display("FAIL basic_empty: got %b expected 1", empty); end
        if (thr_low !== 1'b1) begin errors++; $display("FAIL basic_thr_low2: got %b expected 1", thr_low); end
        // rd_ready while empty must be ignored
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (level !== 5'd0) begin errors++; $display("FAIL empty_pop_level: got %0d expected 0", level); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        checks += 3;
        if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
        if (level !== 5'd16)   begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
        if (ovr_err !== 1'b0)  begin errors++; $display("FAIL ovf_pre: got %b expected 0", ovr_err); end
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (ovr_err !== exp_ovr) begin errors++; $display("FAIL ovf_err: got %b expected %b", ovr_err, exp_ovr); end
        if (level !== 5'd16)     begin errors++; $display("FAIL ovf_level2: got %0d expected 16", level); end
        pops = 0;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (empty !== 1'b1 || pops != DEPTH) begin errors++; $display("FAIL ovf_drain: empty %b pops %0d expected 1 and 16", empty, pops); end
        if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovr_err); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ovr_err !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b expected 0", ovr_err); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        checks += 2;
        if (level !== 5'd16)  begin errors++; $display("FAIL fullpop_level: got %0d expected 16", level); end
        if (ovr_err !== 1'b0) begin errors++; $display("FAIL fullpop_ovr: got %b expected 0", ovr_err); end
        checks++;
        if (mq[DEPTH-1] !== 8'h55) begin errors++; $display("FAIL fullpop_order: model tail %h expected 55", mq[DEPTH-1]); end
        pops = 0;
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (empty !== 1'b1 || pops != DEPTH) begin errors++; $display("FAIL fullpop_drain: empty %b pops %0d expected 1 and 16", empty, pops); end
    endtask

    task automatic test_wrap();
        pops = 0;
        step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pops != 20 || empty !== 1'b1) begin errors++; $display("FAIL wrap_count: pops %0d empty %b expected 20 and 1", pops, empty); end
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", ovr_err); end
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        checks += 4;
        if (level !== 5'd0)      begin errors++; $display("FAIL clr_level: got %0d expected 0", level); end
        if (empty !== 1'b1)      begin errors++; $display("FAIL clr_empty: got %b expected 1", empty); end
        if (rd_valid !== 1'b0)   begin errors++; $display("FAIL clr_valid: got %b expected 0", rd_valid); end
        if (ovr_err !== exp_ovr) begin errors++; $display("FAIL clr_ovr: got %b expected %b", ovr_err, exp_ovr); end
        step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        checks += 2;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL clr_push_valid: got %b expected 1", rd_valid); end
        if (rd_data !== 8'h7E) begin errors++; $display("FAIL clr_push_data: got %h expected 7E", rd_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        rd_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks += 3;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", rd_valid); end
        if (level !== 5'd0)    begin errors++; $display("FAIL arst_level: got %0d expected 0", level); end
        if (ovr_err !== 1'b0)  begin errors++; $display("FAIL arst_ovr: got %b expected 0", ovr_err); end
        rd_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        mq.delete(); exp_ovr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_clr();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
